// File: rtl/keypad_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM states, key-code map
// and the column strobe reset pattern.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } scan_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    // Indexed as KEY_MAP[row][col]; leftmost nibble is row 0, column 0.
    localparam logic [0:3][0:3][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous level inputs such as keypad rows
// or push buttons.
module sync2 #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold column strobe, debounces a
// single press and hands its hex code to the consumer over valid/ready.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] MATCH_TARGET = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] MATCH_ONE    = CNT_W'(1);

    logic [3:0]       row_sync;
    logic             sample;
    logic             push;
    logic             accept;

    logic [DIV_W-1:0] div_q, div_d;
    scan_state_t      state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             overrun_q, overrun_d;

    sync2 #(.WIDTH(4), .RESET_VALUE(4'hF)) u_row_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (row),
        .q      (row_sync)
    );

    always_comb begin
        sample = (div_q == DIV_LAST);
        div_d  = sample ? '0 : div_q + 1'b1;
    end

    // The column index doubles as the latched column while a key is tracked.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        match_d    = match_q;
        key_held_d = key_held_q;
        push       = 1'b0;
        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (row_sync != 4'hF) begin
                        row_idx_d = lowest_low_row(row_sync);
                        match_d   = MATCH_ONE;
                        state_d   = (MATCH_TARGET == MATCH_ONE) ? PRESSED : DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (!row_sync[row_idx_q]) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MATCH_TARGET) state_d = PRESSED;
                    end else begin
                        match_d   = '0;
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            PRESSED: begin
                push       = 1'b1;
                key_held_d = 1'b1;
                match_d    = '0;
                state_d    = RELEASE;
            end
            RELEASE: begin
                if (sample) begin
                    if (row_sync[row_idx_q]) begin
                        match_d = match_q + 1'b1;
                        if (match_d == MATCH_TARGET) begin
                            match_d    = '0;
                            key_held_d = 1'b0;
                            state_d    = SCAN;
                            col_idx_d  = col_idx_q + 2'd1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
            end
            default: state_d = SCAN;
        endcase
        col_d = ~(4'b0001 << col_idx_d);
    end

    // A push into a full, unaccepted buffer is dropped and flagged instead.
    always_comb begin
        accept      = key_valid_q && key_ready;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (accept) begin
            key_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (push) begin
            if (!key_valid_q || key_ready) begin
                key_valid_d = 1'b1;
                key_code_d  = KEY_MAP[row_idx_q][col_idx_q];
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q       <= '0;
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            match_q     <= '0;
            col_q       <= COL_RESET;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            match_q     <= match_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad matrix model closes rows
// against the driven column, and hand-derived expectations are checked.
module tb_keypad_scanner;

    logic       clk;
    logic       reset_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overrun;

    logic [15:0] keys_down;
    int          check_count = 0;
    int          pass_count = 0;
    int          accepted_count = 0;
    int          base_count;
    int          n;
    logic [3:0]  last_code = 4'h0;
    logic [3:0]  prev_col;
    logic [3:0]  walk_exp [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key_held (key_held),
        .overrun  (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A closed key pulls its row low only while its column is strobed.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys_down[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n && key_valid && key_ready) begin
            accepted_count++;
            last_code = key_code;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input int r, input int c, input logic down);
        keys_down[r*4+c] = down;
    endtask

    task automatic waitColEntry(input logic [3:0] target, input string tag);
        int k;
        k = 0;
        while (col == target && k < 40) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (col != target && k < 40) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, col, target);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        keys_down = '0;
        key_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset_col", col, 4'b1110);
        checkOutput("reset_valid", key_valid, 1'b0);
        checkOutput("reset_held", key_held, 1'b0);
        checkOutput("reset_overrun", overrun, 1'b0);

        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            prev_col = col;
            n = 0;
            while (col == prev_col && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkOutput("walk_col", col, walk_exp[i]);
            checkOutput("walk_dwell", n, 4);
        end

        $display("[TB] press 5 with key_ready high");
        applyStimulus(1, 1, 1'b1);
        repeat (80) @(negedge clk);
        checkOutput("press5_held", key_held, 1'b1);
        applyStimulus(1, 1, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("press5_held_after_release", key_held, 1'b1);
        repeat (14) @(negedge clk);
        checkOutput("press5_held_cleared", key_held, 1'b0);
        checkOutput("press5_pulses", accepted_count, 1);
        checkOutput("press5_code", last_code, 4'h5);
        checkOutput("press5_valid_low", key_valid, 1'b0);

        $display("[TB] single-sample bounce on row 0");
        base_count = accepted_count;
        waitColEntry(4'b1110, "bounce_col_entry");
        applyStimulus(0, 0, 1'b1);
        repeat (4) @(negedge clk);
        applyStimulus(0, 0, 1'b0);
        n = 0;
        while (col == 4'b1110 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bounce_resume_col", col, 4'b1101);
        checkOutput("bounce_valid", key_valid, 1'b0);
        checkOutput("bounce_held", key_held, 1'b0);
        checkOutput("bounce_pulses", accepted_count, base_count);

        $display("[TB] rows 2 and 3 low together in column 3");
        base_count = accepted_count;
        applyStimulus(2, 3, 1'b1);
        applyStimulus(3, 3, 1'b1);
        n = 0;
        while (accepted_count == base_count && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tworow_pulses", accepted_count, base_count + 1);
        checkOutput("tworow_code", last_code, 4'hC);
        applyStimulus(2, 3, 1'b0);
        applyStimulus(3, 3, 1'b0);
        n = 0;
        while (key_held && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tworow_released", key_held, 1'b0);

        $display("[TB] overrun with key_ready low");
        key_ready  = 1'b0;
        base_count = accepted_count;
        applyStimulus(0, 0, 1'b1);
        n = 0;
        while (!key_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ovr_first_valid", key_valid, 1'b1);
        applyStimulus(0, 0, 1'b0);
        n = 0;
        while (key_held && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ovr_first_released", key_held, 1'b0);
        applyStimulus(3, 3, 1'b1);
        n = 0;
        while (!key_held && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ovr_second_held", key_held, 1'b1);
        checkOutput("ovr_code_kept", key_code, 4'h1);
        checkOutput("ovr_flag", overrun, 1'b1);
        checkOutput("ovr_valid_kept", key_valid, 1'b1);
        applyStimulus(3, 3, 1'b0);
        n = 0;
        while (key_held && n < 50) begin
            @(negedge clk);
            n++;
        end
        key_ready = 1'b1;
        @(negedge clk);
        checkOutput("ovr_valid_after_accept", key_valid, 1'b0);
        checkOutput("ovr_flag_cleared", overrun, 1'b0);
        checkOutput("ovr_accepted_code", last_code, 4'h1);
        checkOutput("ovr_pulses", accepted_count, base_count + 1);

        $display("[TB] reset during debounce of 9");
        base_count = accepted_count;
        waitColEntry(4'b1101, "pre9_col_entry");
        applyStimulus(2, 2, 1'b1);
        waitColEntry(4'b1011, "key9_col_entry");
        repeat (6) @(negedge clk);
        checkOutput("key9_col_frozen", col, 4'b1011);
        reset_n = 1'b0;
        applyStimulus(2, 2, 1'b0);
        @(negedge clk);
        checkOutput("key9_reset_col", col, 4'b1110);
        checkOutput("key9_reset_valid", key_valid, 1'b0);
        checkOutput("key9_reset_held", key_held, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("key9_no_pulse", accepted_count, base_count);
        checkOutput("key9_valid_low", key_valid, 1'b0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the calculator's seven-segment output path. The block drives the column lines of a 4x4 matrix keypad one at a time and reads its row lines. It debounces a single key press and delivers it as a 4-bit hex key code over a valid/ready handshake to the operand-entry logic ahead of the ALU. The column strobing mirrors the anode multiplexing on the display side: one active-low line at a time, rotating.

## Interface
- SCAN_DIV, default 100000: clock cycles per column dwell (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_SCANS, default 10: consecutive matching row samples needed to accept a press or a release; minimum 1.
- clk  in  1  system clock; the block uses one clock.
- reset_n  in  1  synchronous, active-low reset.
- row  in  4  keypad rows; active-low, externally pulled up; asynchronous to clk.
- col  out  4  keypad column strobe; one-cold, active-low.
- key_code  out  4  hex code of the accepted key.
- key_valid  out  1  key_code is valid; held until accepted.
- key_ready  in  1  consumer accepts when key_valid && key_ready.
- key_held  out  1  high from acceptance of a press until its debounced release.
- overrun  out  1  a press was dropped because the buffer was full.

## Operation
- Rows pass through a 2-flop synchronizer before any use.
- The dwell divider counts 0..SCAN_DIV-1. Rows are sampled on the cycle the divider equals SCAN_DIV-1, called the sample cycle.
- States:
  - SCAN: on each sample cycle, if any synchronized row is low, latch the column index and row index and go to DEBOUNCE with match count 1; col freezes. Otherwise col rotates 1110->1101->1011->0111->1110.
  - If several rows are low in the same sample, the lowest row index is latched.
  - DEBOUNCE: on each sample cycle, if the latched row is still low, increment the match count; on reaching DEBOUNCE_SCANS go to PRESSED. If the latched row is high, go to SCAN and resume rotation from the next column.
  - PRESSED: lasts one cycle. Pushes the code into the output buffer, sets key_held, and goes to RELEASE.
  - RELEASE: col stays frozen. Wait for DEBOUNCE_SCANS consecutive samples with the latched row high; any low sample restarts the count. Then clear key_held, go to SCAN, and rotate to the next column.
- The code map is indexed as row r, column c and lives in the shared package:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Output buffer holds one entry:
  - A push with buffer empty, or full but accepted in the same cycle, loads key_code and keeps or sets key_valid.
  - A push while key_valid && !key_ready drops the new code; key_code is unchanged and overrun is set.
  - overrun clears on the next accepted handshake.
  - key_code is stable while key_valid is high.

## Timing
- Reset values:
  - col=1110, key_code=0, key_valid=0, key_held=0, overrun=0.
  - State SCAN, divider 0, match count 0, synchronizer flops 1111.
- Reset asserted mid-operation returns to these values on the next edge. A pending key is discarded.
- Press latency: a stable press reaches the sampler 2 cycles later, through the synchronizer. key_valid rises one cycle after the DEBOUNCE_SCANS-th matching sample. key_held rises in the same cycle as key_valid.
- Handshake: the transfer happens on the clock edge where key_valid && key_ready are both high. key_valid drops the next cycle unless a push coincides.
- col changes only on the cycle after a sample cycle.

## Structure
- Shared package `keypad_pkg`:
  - state enum: SCAN, DEBOUNCE, PRESSED, RELEASE;
  - 4x4 key-code map constant;
  - column one-cold reset constant 4'b1110.
- Sub-module `sync2`: a 2-flop synchronizer, 4 bits wide, reusable for the buttons.
- Divider, FSM and output buffer stay in the top module.

## Test plan
Benches run with SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- Reset: hold reset_n=0 for 5 cycles -> col=1110, key_valid=0, key_held=0, overrun=0. Release reset -> col walks 1101, 1011, 0111, 1110 at 4-cycle intervals.
- Press "5" (row1 low while col=1101) with key_ready=1, held 20 dwells -> exactly one key_valid pulse with key_code=5. key_held=1 until 3 high samples after release.
- Bounce: row0 low for 1 sample then high at col=1110 -> no key_valid. Rotation resumes at 1101.
- Two rows low together at col=0111 (row2 and row3) -> key_code=C.
- Overrun: key_ready=0, press "1" and release, then press "D" -> key_code stays 1, overrun=1. Raise key_ready -> handshake completes, overrun clears, key_valid falls.
- Reset asserted during DEBOUNCE of "9" -> no key_valid. col=1110 on the next cycle.
